// File: rtl/imem_fetch_buf.sv
// ---------------------------------------------------------------------------
// imem_fetch_buf
//
// Instruction memory for the MIPS fetch stage. PC requests arrive over a
// valid/ready handshake. Each accepted request reads the instruction array
// and lands in a 2-entry response FIFO, so decode can stall without losing
// fetches. A write port loads the program. A flush input discards buffered
// responses on a branch redirect.
//
// Parameters
//   DATA_W    : instruction width
//   ADDR_W    : PC width
//   DEPTH     : number of instruction words (>= 2)
//   BYTE_ADDR : 0 -> index = PC, 1 -> index = PC >> 2
//   NOP_WORD  : word returned for out-of-range fetches
//
// Ports
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid / req_ready / req_pc : fetch request handshake
//   rsp_valid / rsp_ready          : response handshake (FIFO head)
//   rsp_inst / rsp_pc / rsp_err    : head instruction, its PC, range error
//   flush                          : drop all buffered responses
//   wr_en / wr_addr / wr_data      : program-load write port
//
// Build option
//   IMEM_RANGE_CHK_EN : when defined, fetches with index >= DEPTH return
//                       NOP_WORD with rsp_err=1, and writes with
//                       wr_addr >= DEPTH are dropped. When undefined, the
//                       index wraps to its low $clog2(DEPTH) bits and
//                       rsp_err is tied to 0.
// ---------------------------------------------------------------------------
module imem_fetch_buf #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 32,
    parameter int                BYTE_ADDR = 0,
    parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_pc,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_inst,
    output logic [ADDR_W-1:0]        rsp_pc,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef IMEM_RANGE_CHK_EN
    localparam int MEM_WORDS = DEPTH;
`else
    // Without range checking the index wraps over the full power-of-two
    // span, so the storage covers every value of the truncated index.
    localparam int MEM_WORDS = 1 << IDX_W;
`endif

    // -----------------------------------------------------------------------
    // Instruction array (contents are never reset)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] fill_inst;
    logic              wr_ok;

`ifdef IMEM_RANGE_CHK_EN
    logic [ADDR_W-1:0] idx_full;
    logic              rd_oor;

    // Index is formed at full PC width so that high PC bits participate in
    // the range check rather than being silently dropped.
    generate
        if (BYTE_ADDR != 0) begin : g_idx_byte
            assign idx_full = req_pc >> 2;
        end else begin : g_idx_word
            assign idx_full = req_pc;
        end

        // With a power-of-two depth every wr_addr value is in range.
        if (DEPTH == (1 << IDX_W)) begin : g_wr_all
            assign wr_ok = 1'b1;
        end else begin : g_wr_chk
            assign wr_ok = (32'(wr_addr) < DEPTH);
        end
    endgenerate

    assign rd_oor    = (idx_full >= ADDR_W'(DEPTH));
    assign rd_idx    = idx_full[IDX_W-1:0];
    assign rd_word   = mem[rd_idx];
    assign fill_inst = rd_oor ? NOP_WORD : rd_word;
`else
    generate
        if (BYTE_ADDR != 0) begin : g_idx_byte
            assign rd_idx = req_pc[IDX_W+1:2];
        end else begin : g_idx_word
            assign rd_idx = req_pc[IDX_W-1:0];
        end
    endgenerate

    assign wr_ok     = 1'b1;
    assign rd_word   = mem[rd_idx];
    assign fill_inst = rd_word;
`endif

    // Non-blocking write: a same-cycle fetch of this index captures the
    // old word, and the new word is seen by fetches from the next cycle.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // 2-entry response FIFO
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] inst_reg [2];
    logic [ADDR_W-1:0] pc_reg   [2];
`ifdef IMEM_RANGE_CHK_EN
    logic              err_reg  [2];
`endif

    logic       head_reg,  head_next;
    logic       tail_reg,  tail_next;
    logic [1:0] count_reg, count_next;
    logic       push;
    logic       pop;
    logic [1:0] ent_we;

    assign req_ready = (count_reg != 2'd2);
    assign rsp_valid = (count_reg != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Incoming fetch always lands at the tail slot, flush or not.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ent_we
            assign ent_we[gi] = push && (tail_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            // Old entries vanish; a request taken this cycle becomes the
            // sole entry, so the head moves to the slot it is written into.
            head_next  = tail_reg;
            tail_next  = tail_reg ^ push;
            count_next = {1'b0, push};
        end else begin
            head_next = head_reg ^ pop;
            tail_next = tail_reg ^ push;
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                inst_reg[i] <= '0;
                pc_reg[i]   <= '0;
`ifdef IMEM_RANGE_CHK_EN
                err_reg[i]  <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ent_we[i]) begin
                    inst_reg[i] <= fill_inst;
                    pc_reg[i]   <= req_pc;
`ifdef IMEM_RANGE_CHK_EN
                    err_reg[i]  <= rd_oor;
`endif
                end
            end
        end
    end

    // Head fields are driven straight from the FIFO registers; the entry
    // contents reset to zero so the outputs read zero out of reset.
    assign rsp_inst = inst_reg[head_reg];
    assign rsp_pc   = pc_reg[head_reg];
`ifdef IMEM_RANGE_CHK_EN
    assign rsp_err  = err_reg[head_reg];
`else
    assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_buf
//
// Directed bench for imem_fetch_buf. Instance u_dut uses the default
// word-addressed 32-deep configuration; u_rng uses DEPTH=20 with byte
// addressing to exercise index mapping and the out-of-range path.
// ---------------------------------------------------------------------------
module tb_imem_fetch_buf;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_pc;
    logic        rsp_err;
    logic        flush;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic        b_req_valid;
    logic        b_req_ready;
    logic [31:0] b_req_pc;
    logic        b_rsp_valid;
    logic        b_rsp_ready;
    logic [31:0] b_rsp_inst;
    logic [31:0] b_rsp_pc;
    logic        b_rsp_err;
    logic        b_flush;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;

    int n_asrt = 0;
    int n_fail = 0;

    logic [31:0] prog [4];

    always #5 clk = ~clk;

    imem_fetch_buf u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_pc    (rsp_pc),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    imem_fetch_buf #(
        .DEPTH     (20),
        .BYTE_ADDR (1),
        .NOP_WORD  (32'h0BAD_0BAD)
    ) u_rng (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_pc    (b_req_pc),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_inst  (b_rsp_inst),
        .rsp_pc    (b_rsp_pc),
        .rsp_err   (b_rsp_err),
        .flush     (b_flush),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_b(input logic [4:0] a, input logic [31:0] d);
        b_wr_en   = 1'b1;
        b_wr_addr = a;
        b_wr_data = d;
        tick();
        b_wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'h0001_1020;
        prog[1] = 32'h0064_2822;
        prog[2] = 32'h00C7_4024;
        prog[3] = 32'h012A_5825;

        rst_n = 1'b0;
        req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        b_req_valid = 1'b0; b_req_pc = '0; b_rsp_ready = 1'b1; b_flush = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;

        // ---- reset state ----
        #2;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_rsp_inst",  rsp_inst,  32'h0);
        chk("rst_rsp_pc",    rsp_pc,    32'h0);
        tick();
        rst_n = 1'b1;

        // ---- program load ----
        for (int i = 0; i < 4; i++) load(5'(i), prog[i]);
        load(5'd5,  32'h1111_1111);
        load(5'd14, 32'h2000_000E);

        // ---- streaming ----
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_pc = 32'(i);
            chk("stream_req_ready", req_ready, 1'b1);
            tick();
            chk("stream_valid", rsp_valid, 1'b1);
            chk("stream_inst",  rsp_inst,  prog[i]);
            chk("stream_pc",    rsp_pc,    32'(i));
            chk("stream_err",   rsp_err,   1'b0);
        end
        req_valid = 1'b0;
        tick();
        chk("stream_drained", rsp_valid, 1'b0);

        // ---- backpressure ----
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'd0;
        tick();
        chk("bp_head_pc0", rsp_pc, 32'd0);
        req_pc = 32'd1;
        chk("bp_ready_cnt1", req_ready, 1'b1);
        tick();
        chk("bp_ready_full", req_ready, 1'b0);
        req_pc = 32'd2;
        tick();
        chk("bp_ready_held", req_ready, 1'b0);
        chk("bp_head_stable_pc",   rsp_pc,   32'd0);
        chk("bp_head_stable_inst", rsp_inst, prog[0]);
        rsp_ready = 1'b1;
        tick();
        chk("bp_ready_reassert", req_ready, 1'b1);
        chk("bp_second_pc",   rsp_pc,   32'd1);
        chk("bp_second_inst", rsp_inst, prog[1]);
        tick();
        chk("bp_third_pc",   rsp_pc,   32'd2);
        chk("bp_third_inst", rsp_inst, prog[2]);
        req_valid = 1'b0;
        tick();
        chk("bp_drained", rsp_valid, 1'b0);

        // ---- flush with redirect (one old entry buffered) ----
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'd2;
        tick();
        flush  = 1'b1;
        req_pc = 32'd14;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_valid",  rsp_valid, 1'b1);
        chk("flush_pc",     rsp_pc,    32'd14);
        chk("flush_inst",   rsp_inst,  32'h2000_000E);
        chk("flush_ready",  req_ready, 1'b1);
        rsp_ready = 1'b1;
        tick();
        chk("flush_single_entry", rsp_valid, 1'b0);

        // ---- flush with full FIFO (request not accepted) ----
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'd2;
        tick();
        req_pc = 32'd3;
        tick();
        chk("flushfull_ready_pre", req_ready, 1'b0);
        flush  = 1'b1;
        req_pc = 32'd14;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flushfull_valid", rsp_valid, 1'b0);
        chk("flushfull_ready", req_ready, 1'b1);

        // ---- read/write collision ----
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'd5;
        wr_en     = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        chk("coll_old_word", rsp_inst, 32'h1111_1111);
        chk("coll_old_pc",   rsp_pc,   32'd5);
        tick();
        chk("coll_new_word", rsp_inst, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        tick();

        // ---- reset mid-operation ----
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'd0;
        tick();
        req_pc = 32'd1;
        tick();
        req_valid = 1'b0;
        chk("midrst_full", req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_rsp_inst",  rsp_inst,  32'h0);
        chk("midrst_rsp_pc",    rsp_pc,    32'h0);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'd1;
        tick();
        chk("postrst_inst1", rsp_inst, prog[1]);
        req_pc = 32'd14;
        tick();
        chk("postrst_inst14", rsp_inst, 32'h2000_000E);
        req_pc = 32'd5;
        tick();
        chk("postrst_inst5", rsp_inst, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        tick();
        chk("postrst_drained", rsp_valid, 1'b0);

        // ---- range check / byte addressing on the DEPTH=20 instance ----
        load_b(5'd0,  32'h0000_1111);
        load_b(5'd3,  32'hCAFE_0003);
        load_b(5'd20, 32'hA5A5_A514);
        b_req_valid = 1'b1;
        b_req_pc    = 32'h0000_000C;
        tick();
        chk("rng_idx3_inst", b_rsp_inst, 32'hCAFE_0003);
        chk("rng_idx3_err",  b_rsp_err,  1'b0);
        b_req_pc = 32'h0000_000F;
        tick();
        chk("rng_lowbits_ignored", b_rsp_inst, 32'hCAFE_0003);
        chk("rng_lowbits_pc",      b_rsp_pc,   32'h0000_000F);
        b_req_pc = 32'h0000_0050;
        tick();
`ifdef IMEM_RANGE_CHK_EN
        chk("rng_idx20_inst", b_rsp_inst, 32'h0BAD_0BAD);
        chk("rng_idx20_err",  b_rsp_err,  1'b1);
`else
        chk("rng_idx20_inst", b_rsp_inst, 32'hA5A5_A514);
        chk("rng_idx20_err",  b_rsp_err,  1'b0);
`endif
        b_req_pc = 32'h8000_0000;
        tick();
`ifdef IMEM_RANGE_CHK_EN
        chk("rng_highpc_inst", b_rsp_inst, 32'h0BAD_0BAD);
        chk("rng_highpc_err",  b_rsp_err,  1'b1);
`else
        chk("rng_highpc_inst", b_rsp_inst, 32'h0000_1111);
        chk("rng_highpc_err",  b_rsp_err,  1'b0);
`endif
        b_req_valid = 1'b0;
        tick();
        chk("rng_drained", b_rsp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
